// File: rtl/drive_sink_fifo.sv
// Sink stage after the mutex merge: stores drive/data words in a FIFO and acknowledges with free.
// 1-cycle write-to-head latency; while full, a drive is parked in a hold register and free is withheld until a pop.
module drive_sink_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, PEND} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] hold;
  state_t                state;
  logic                  free_q;
  logic                  err_q;

  logic                  full, empty, pop;
  logic                  drive_bad, go_pend, wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && i_ready;

  // A drive arriving while a word is parked, or while free is still being returned, breaks the handshake.
  always_comb begin
    drive_bad = i_drive && (state == PEND || free_q);
    go_pend   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = i_data;
    if (state == PEND) begin
      if (pop) begin
        wr_en   = 1'b1;
        wr_data = hold;
      end
    end else if (i_drive && !free_q) begin
      if (!full || pop) wr_en   = 1'b1;
      else              go_pend = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hold   <= '0;
      free_q <= 1'b0;
      err_q  <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      free_q <= wr_en;
      if (drive_bad) err_q <= 1'b1;
      if (go_pend) begin
        hold  <= i_data;
        state <= PEND;
      end else if (state == PEND && pop) begin
        state <= IDLE;
      end
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty slots may hold stale words, so the head is masked rather than the array reset.
  assign o_data  = empty ? '0 : mem[rd_ptr];
  assign o_valid = !empty;
  assign o_free  = free_q;
  assign o_count = count;
  assign o_err   = err_q;

endmodule

// File: tb/tb_drive_sink_fifo.sv
// Bench for drive_sink_fifo: directed scenarios plus random legal traffic against a queue-based model.
module tb_drive_sink_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_drive = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_free;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_err;

  drive_sink_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: list of stored words, one parked word, free-owed flag, sticky error.
  logic [DW-1:0] mq[$];
  bit            m_pend;
  logic [DW-1:0] m_pword;
  bit            m_free;
  bit            m_err;

  task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, ".free"},  DW'(o_free),  DW'(m_free));
    chk_eq({tag, ".valid"}, DW'(o_valid), DW'(mq.size() != 0));
    chk_eq({tag, ".data"},  o_data,       (mq.size() != 0) ? mq[0] : '0);
    chk_eq({tag, ".count"}, DW'(o_count), DW'(mq.size()));
    chk_eq({tag, ".err"},   DW'(o_err),   DW'(m_err));
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend = 0; m_pword = '0; m_free = 0; m_err = 0;
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input string tag, input bit drv, input logic [DW-1:0] dat, input bit rdy);
    bit pop, wr, pend0;
    logic [DW-1:0] wd;
    i_drive = drv; i_data = dat; i_ready = rdy;
    @(posedge clk);
    pend0 = m_pend;
    pop = rdy && (mq.size() > 0);
    wr = 0; wd = '0;
    if (drv && (pend0 || m_free)) m_err = 1;
    else if (drv) begin
      if (mq.size() < DEPTH || pop) begin wr = 1; wd = dat; end
      else begin m_pend = 1; m_pword = dat; end
    end
    if (pend0 && pop) begin wr = 1; wd = m_pword; m_pend = 0; end
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back(wd);
    m_free = wr;
    #1;
    check_all(tag);
  endtask

  task automatic fill(input string tag, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      step(tag, 1'b1, base + DW'(k), 1'b0);
      step(tag, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    i_drive = 0; i_ready = 0; i_data = '0;
    #2 rst = 0;
    #1;
    chk_eq({tag, ".rst_free"},  DW'(o_free),  '0);
    chk_eq({tag, ".rst_valid"}, DW'(o_valid), '0);
    chk_eq({tag, ".rst_data"},  o_data,       '0);
    chk_eq({tag, ".rst_count"}, DW'(o_count), '0);
    chk_eq({tag, ".rst_err"},   DW'(o_err),   '0);
    model_clear();
    @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    bit busy;
    bit drv, rdy;
    logic [DW-1:0] w;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1;

    // 1: single word, first-word latency and free timing
    step("t1", 1'b1, DW'(8'hA5), 1'b0);
    chk_eq("t1.free_after_drive", DW'(o_free), DW'(1));
    chk_eq("t1.head", o_data, DW'(8'hA5));
    step("t1", 1'b0, '0, 1'b0);
    chk_eq("t1.free_one_cycle", DW'(o_free), '0);
    step("t1", 1'b0, '0, 1'b1);

    // 2: fill, park fifth word, single pop releases it
    fill("t2", 4, DW'(1));
    chk_eq("t2.full", DW'(o_count), DW'(4));
    step("t2", 1'b1, DW'(5), 1'b0);
    repeat (3) step("t2.pend", 1'b0, '0, 1'b0);
    step("t2.pop", 1'b0, '0, 1'b1);
    chk_eq("t2.free_after_pop", DW'(o_free), DW'(1));
    chk_eq("t2.count_kept", DW'(o_count), DW'(4));
    for (int k = 2; k <= 5; k++) begin
      chk_eq("t2.order", o_data, DW'(k));
      step("t2.drain", 1'b0, '0, 1'b1);
    end

    // 3: drive into a full FIFO during a pop
    fill("t3", 4, DW'(8'h20));
    step("t3", 1'b1, DW'(9), 1'b1);
    chk_eq("t3.free_now", DW'(o_free), DW'(1));
    chk_eq("t3.count", DW'(o_count), DW'(4));
    repeat (5) step("t3.drain", 1'b0, '0, 1'b1);

    // 4: protocol violation while parked
    fill("t4", 4, DW'(8'h30));
    step("t4", 1'b1, DW'(8'h10), 1'b0);
    step("t4.bad", 1'b1, DW'(8'h77), 1'b0);
    chk_eq("t4.err", DW'(o_err), DW'(1));
    step("t4", 1'b0, '0, 1'b0);
    step("t4.pop", 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step("t4.drain", 1'b0, '0, 1'b1);
      chk_eq("t4.no77", DW'(o_data == DW'(8'h77)), '0);
    end
    chk_eq("t4.err_sticky", DW'(o_err), DW'(1));
    do_reset("t4");

    // 5: streaming through with wrap-around
    for (int k = 0; k < 20; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      step("t5", 1'b1, w, 1'b1);
      chk_eq("t5.cnt_le1", DW'(o_count <= 1), DW'(1));
      step("t5", 1'b0, '0, 1'b1);
    end

    // 6: async reset while parked
    fill("t6", 4, DW'(8'h40));
    step("t6", 1'b1, DW'(8'h55), 1'b0);
    do_reset("t6");
    repeat (2) step("t6.idle", 1'b0, '0, 1'b0);
    step("t6.next", 1'b1, DW'(8'h66), 1'b0);
    chk_eq("t6.count1", DW'(o_count), DW'(1));
    step("t6", 1'b0, '0, 1'b1);

    // Random legal traffic with varying consumer throttle
    busy = 0;
    for (int k = 0; k < 3000; k++) begin
      rdy = ($urandom_range(0, 3) < ((k / 500) % 4)) ? 1'b1 : 1'b0;
      drv = !busy && !m_free && ($urandom_range(0, 2) != 0);
      w = {$urandom, $urandom, $urandom, $urandom};
      step("rand", drv, drv ? w : '0, rdy);
      if (drv) busy = 1;
      if (m_free) busy = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
